division_sequencer: RTL and testbench

Controls signed 4-bit division in the calculator datapath. On start it captures two's-complement operands and uses the shared two-operand complement unit to form magnitudes. It then runs a 4-iteration restoring shift-subtract on the magnitudes, uses the same unit again to restore signs, and returns quotient and remainder through a start/done handshake. It sits between the operation decoder/ALU select logic and the shared complement unit.

---
 rtl/div_ctrl_pkg.sv | 22 ++
 rtl/division_shift_sub_step.sv | 39 +++
 rtl/division_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_division_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// div_ctrl_pkg
// Shared definitions for the signed division sequencer: default operand
// width, FSM state encoding and the most-negative operand constant that
// marks the -8 / -1 overflow case.
// ---------------------------------------------------------------------------
package div_ctrl_pkg;

  localparam int DEF_WIDTH = 4;

  // Most negative two's-complement value at the default width.
  localparam logic [DEF_WIDTH-1:0] MOST_NEG = 4'b1000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    NEG_IN  = 3'd1,
    DIVIDE  = 3'd2,
    NEG_OUT = 3'd3,
    DONE    = 3'd4
  } div_state_t;

endpackage

// File: rtl/division_shift_sub_step.sv
// ---------------------------------------------------------------------------
// division_shift_sub_step
// One combinational restoring-division iteration on unsigned magnitudes.
// Ports:
//   r_in  : partial remainder before the step
//   q_in  : remaining dividend bits / quotient bits collected so far
//   b_in  : divisor magnitude (may be 1000 = unsigned 8)
//   r_out : partial remainder after the step
//   q_out : {q_in shifted left, new quotient bit}
// ---------------------------------------------------------------------------
module division_shift_sub_step
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] r_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] r_out,
  output logic [WIDTH-1:0] q_out
);

  // Shifted remainder needs one extra bit so the compare against an
  // 8-valued magnitude cannot wrap.
  logic [WIDTH:0] r_sh;

  always_comb begin
    r_sh = {r_in, q_in[WIDTH-1]};
    if (r_sh >= {1'b0, b_in}) begin
      // Difference is below b_in, so it always fits in WIDTH bits.
      r_out = r_sh[WIDTH-1:0] - b_in;
      q_out = {q_in[WIDTH-2:0], 1'b1};
    end else begin
      r_out = r_sh[WIDTH-1:0];
      q_out = {q_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/division_sequencer.sv
// ---------------------------------------------------------------------------
// division_sequencer
// Signed WIDTH-bit division controller. Operands are converted to
// magnitudes through the shared complement unit, divided by ITER restoring
// shift-subtract iterations, and the signs are restored through the same
// unit. Quotient truncates toward zero; the remainder takes the dividend's
// sign.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   start                     : request, sampled only in IDLE
//   dividend, divisor         : signed operands
//   comp_sel                  : request to shared complement unit
//   comp_a, comp_b            : values to negate (stable while comp_sel=1)
//   comp_first, comp_second   : negations, valid while comp_finish=1
//   comp_finish               : complement unit acknowledge
//   busy                      : high in every state except IDLE
//   done                      : one-cycle completion pulse
//   quotient, remainder       : signed results, held until next start
//   div_by_zero, overflow     : status of the last operation
// ---------------------------------------------------------------------------
module division_sequencer
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ITER  = WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] dividend,
  input  logic signed [WIDTH-1:0] divisor,
  output logic                    comp_sel,
  output logic [WIDTH-1:0]        comp_a,
  output logic [WIDTH-1:0]        comp_b,
  input  logic [WIDTH-1:0]        comp_first,
  input  logic [WIDTH-1:0]        comp_second,
  input  logic                    comp_finish,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] quotient,
  output logic signed [WIDTH-1:0] remainder,
  output logic                    div_by_zero,
  output logic                    overflow
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  div_state_t       state;
  logic             sd;          // dividend sign
  logic             sv;          // divisor sign
  logic             comp_armed;  // first comp_sel cycle has passed
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] q_work;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  function automatic logic is_overflow(input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b);
    return (a == WIDTH'(MOST_NEG)) && (b == '1);
  endfunction

  division_shift_sub_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r_in  (r_work),
    .q_in  (q_work),
    .b_in  (b_mag),
    .r_out (r_next),
    .q_out (q_next)
  );

  // comp_a / comp_b double as the latched operands (NEG_IN) and the
  // latched unsigned results (NEG_OUT), so no separate copies are kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sd          <= 1'b0;
      sv          <= 1'b0;
      comp_armed  <= 1'b0;
      cnt         <= '0;
      r_work      <= '0;
      q_work      <= '0;
      b_mag       <= '0;
      comp_sel    <= 1'b0;
      comp_a      <= '0;
      comp_b      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        // Accept a request and pick the first working state
        IDLE: begin
          if (start) begin
            sd          <= dividend[WIDTH-1];
            sv          <= divisor[WIDTH-1];
            div_by_zero <= 1'b0;
            overflow    <= is_overflow(dividend, divisor);
            busy        <= 1'b1;
            if (divisor == '0) begin
              quotient    <= '0;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else if (dividend[WIDTH-1] || divisor[WIDTH-1]) begin
              comp_sel   <= 1'b1;
              comp_a     <= dividend;
              comp_b     <= divisor;
              comp_armed <= 1'b0;
              state      <= NEG_IN;
            end else begin
              q_work <= dividend;
              r_work <= '0;
              b_mag  <= divisor;
              cnt    <= '0;
              state  <= DIVIDE;
            end
          end
        end

        // Operand magnitudes from the complement unit
        NEG_IN: begin
          if (!comp_armed) begin
            comp_armed <= 1'b1;
          end else if (comp_finish) begin
            q_work   <= sd ? comp_first : comp_a;
            b_mag    <= sv ? comp_second : comp_b;
            r_work   <= '0;
            cnt      <= '0;
            comp_sel <= 1'b0;
            state    <= DIVIDE;
          end
        end

        // Restoring shift-subtract, one bit per cycle
        DIVIDE: begin
          r_work <= r_next;
          q_work <= q_next;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(ITER - 1)) begin
            if ((sd ^ sv) || sd) begin
              comp_sel   <= 1'b1;
              comp_a     <= q_next;
              comp_b     <= r_next;
              comp_armed <= 1'b0;
              state      <= NEG_OUT;
            end else begin
              quotient  <= q_next;
              remainder <= r_next;
              done      <= 1'b1;
              state     <= DONE;
            end
          end
        end

        // Sign restoration through the complement unit
        NEG_OUT: begin
          if (!comp_armed) begin
            comp_armed <= 1'b1;
          end else if (comp_finish) begin
            quotient  <= (sd ^ sv) ? comp_first : comp_a;
            remainder <= sd ? comp_second : comp_b;
            comp_sel  <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end

        // Completion pulse, results stay on the outputs
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          comp_sel <= 1'b0;
          done     <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_division_sequencer.sv
// ---------------------------------------------------------------------------
// tb_division_sequencer
// Scoreboard bench: stimulus pushes hand-computed results, a monitor pops
// and compares them on every done pulse. A behavioural complement unit
// answers comp_sel after a programmable number of cycles.
// ---------------------------------------------------------------------------
module tb_division_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       comp_sel;
  logic [3:0] comp_a;
  logic [3:0] comp_b;
  logic [3:0] comp_first;
  logic [3:0] comp_second;
  logic       comp_finish;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  logic       overflow;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
    logic       ovf;
    int         lat;
    int         hs;
    int         t0;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   comp_lat = 3;

  division_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .comp_sel    (comp_sel),
    .comp_a      (comp_a),
    .comp_b      (comp_b),
    .comp_first  (comp_first),
    .comp_second (comp_second),
    .comp_finish (comp_finish),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Complement unit: raises comp_finish comp_lat cycles after it sees a
  // request, holds it one cycle, then re-arms.
  initial begin
    int cnt;
    cnt         = 0;
    comp_finish = 1'b0;
    comp_first  = 4'd0;
    comp_second = 4'd0;
    forever begin
      @(posedge clk);
      #1;
      if (comp_sel && !comp_finish) begin
        if (cnt >= comp_lat) begin
          comp_first  = ~comp_a + 4'd1;
          comp_second = ~comp_b + 4'd1;
          comp_finish = 1'b1;
          cnt         = 0;
        end else begin
          cnt++;
        end
      end else begin
        comp_finish = 1'b0;
        cnt         = 0;
      end
    end
  end

  // Monitor: counts complement requests and checks every done pulse.
  initial begin
    int   hs;
    logic prev_sel;
    logic prev_done;
    exp_t e;
    hs        = 0;
    prev_sel  = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hs        = 0;
        prev_sel  = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (comp_sel && !prev_sel) hs++;
        if (done) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 required no pulse (t=%0t)", $time);
          end else begin
            e = sb.pop_front();
            chk("quotient",    int'(quotient),    int'(e.q));
            chk("remainder",   int'(remainder),   int'(e.r));
            chk("div_by_zero", int'(div_by_zero), int'(e.dbz));
            chk("overflow",    int'(overflow),    int'(e.ovf));
            chk("latency",     cyc - e.t0,        e.lat);
            chk("handshakes",  hs,                e.hs);
            chk("done_pulse",  int'(prev_done),   0);
          end
          hs = 0;
        end
        prev_sel  = comp_sel;
        prev_done = done;
      end
    end
  end

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int lat,
                        input logic [3:0] eq, input logic [3:0] er,
                        input logic edbz, input logic eovf,
                        input int elat, input int ehs, input bit busy_starts);
    exp_t e;
    bit   got;
    @(posedge clk);
    #1;
    comp_lat = lat;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e.q = eq; e.r = er; e.dbz = edbz; e.ovf = eovf;
    e.lat = elat; e.hs = ehs; e.t0 = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    got   = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (busy_starts && i == 1) begin
        start    = 1'b1;
        dividend = 4'd5;
        divisor  = 4'd0;
      end else if (i == 3) begin
        start = 1'b0;
      end
      if (done) got = 1'b1;
    end
    start = 1'b0;
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got no done for %0d/%0d required done", a, b);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test required $finish");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = 4'd0;
    divisor  = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",      int'(busy),        0);
    chk("rst_done",      int'(done),        0);
    chk("rst_comp_sel",  int'(comp_sel),    0);
    chk("rst_quotient",  int'(quotient),    0);
    chk("rst_remainder", int'(remainder),   0);
    chk("rst_flags",     int'({div_by_zero, overflow}), 0);
    @(negedge clk);
    rst = 1'b0;

    //      a        b        lat q        r        dbz   ovf   lat hs busy
    run_op(4'b0111, 4'b0010, 3, 4'b0011, 4'b0001, 1'b0, 1'b0,  5, 0, 1'b0); // 7/2
    run_op(4'b1001, 4'b0010, 3, 4'b1101, 4'b1111, 1'b0, 1'b0, 13, 2, 1'b0); // -7/2
    run_op(4'b0111, 4'b1110, 3, 4'b1101, 4'b0001, 1'b0, 1'b0, 13, 2, 1'b0); // 7/-2
    run_op(4'b1010, 4'b1101, 1, 4'b0010, 4'b0000, 1'b0, 1'b0,  9, 2, 1'b0); // -6/-3
    run_op(4'b1000, 4'b0010, 0, 4'b1100, 4'b0000, 1'b0, 1'b0, 11, 2, 1'b0); // -8/2
    run_op(4'b0101, 4'b0000, 3, 4'b0000, 4'b0101, 1'b1, 1'b0,  1, 0, 1'b0); // 5/0
    run_op(4'b0011, 4'b0101, 3, 4'b0000, 4'b0011, 1'b0, 1'b0,  5, 0, 1'b0); // 3/5
    run_op(4'b1111, 4'b0111, 3, 4'b0000, 4'b1111, 1'b0, 1'b0, 13, 2, 1'b0); // -1/7
    run_op(4'b1000, 4'b1111, 2, 4'b1000, 4'b0000, 1'b0, 1'b1, 11, 2, 1'b0); // -8/-1

    // Abort 7/3 with reset in its second DIVIDE cycle.
    @(posedge clk);
    #1;
    dividend = 4'd7;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("abort_busy", int'(busy), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy0",      int'(busy),      0);
    chk("abort_done0",      int'(done),      0);
    chk("abort_comp_sel0",  int'(comp_sel),  0);
    chk("abort_quotient0",  int'(quotient),  0);
    chk("abort_remainder0", int'(remainder), 0);
    chk("abort_flags0",     int'({div_by_zero, overflow}), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 6/3 with start pulses (5/0) while busy that must be dropped.
    run_op(4'b0110, 4'b0011, 3, 4'b0010, 4'b0000, 1'b0, 1'b0,  5, 0, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    chk("idle_busy",  int'(busy), 0);
    chk("sb_empty",   sb.size(),  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
